// File: rtl/isqrt_seq.sv
// isqrt_seq: iterative integer square root, one result bit per clock (shift/subtract).
// Optional feature macro: ISQRT_REM_EN adds the rem_bo remainder output.
// Ports: clk_i clock; rst_i sync active-high reset; x_bi radicand; start_i request (IDLE only);
//        busy_o operation in progress; done_o one-cycle result pulse;
//        y_bo floor(sqrt(x)) zero-extended; rem_bo x - y*y (ISQRT_REM_EN only).
module isqrt_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] x_bi,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_bo
`ifdef ISQRT_REM_EN
  ,
  output logic [WIDTH/2:0] rem_bo
`endif
);
  localparam int CW = $clog2(WIDTH / 2);
  typedef enum logic {IDLE, CALC} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] x_q, m_q, r_q, y_q, b, x_d, r_d;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             ge;
`ifdef ISQRT_REM_EN
  logic [WIDTH/2:0] rem_q;
  assign rem_bo = rem_q;
`endif
  always_comb begin
    b   = r_q | m_q;
    ge  = x_q >= b;
    x_d = ge ? x_q - b : x_q;
    r_d = ge ? (r_q >> 1) | m_q : r_q >> 1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
`ifdef ISQRT_REM_EN
      rem_q   <= '0;
`endif
    end else if (state_q == IDLE) begin
      done_q <= 1'b0;
      if (start_i) begin
        x_q     <= x_bi;
        m_q     <= WIDTH'(1) << (WIDTH - 2);
        r_q     <= '0;
        cnt_q   <= CW'(WIDTH / 2 - 1);
        state_q <= CALC;
      end
    end else begin
      x_q <= x_d;
      r_q <= r_d;
      m_q <= m_q >> 2;
      if (cnt_q == '0) begin
        state_q <= IDLE;
        y_q     <= r_d;
        done_q  <= 1'b1;
`ifdef ISQRT_REM_EN
        // the final residual is below 2*y+1, so it fits in WIDTH/2+1 bits
        rem_q   <= x_d[WIDTH/2:0];
`endif
      end else begin
        cnt_q  <= cnt_q - 1'b1;
        done_q <= 1'b0;
      end
    end
  end
  assign busy_o = state_q == CALC;
  assign done_o = done_q;
  assign y_bo   = y_q;
endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: directed and sweep checks of isqrt_seq against a cycle-level floor-sqrt model.
module tb_isqrt_seq;
  localparam int W = 8;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] x_bi = '0;
  logic         start_i = 1'b0;
  logic         busy_o, done_o;
  logic [W-1:0] y_bo;
`ifdef ISQRT_REM_EN
  logic [W/2:0] rem_bo;
`endif
  isqrt_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .x_bi(x_bi),
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .y_bo(y_bo)
`ifdef ISQRT_REM_EN
    ,
    .rem_bo(rem_bo)
`endif
  );
  always #5 clk_i = ~clk_i;
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int fsqrt(input int x);
    int y = 0;
    while ((y + 1) * (y + 1) <= x) y++;
    return y;
  endfunction
  int           cnt_m = 0;
  int           x_m = 0;
  bit           done_m = 0;
  int           y_m = 0;
  int           rem_m = 0;
  always @(posedge clk_i) begin
    if (rst_i) begin
      cnt_m  <= 0;
      done_m <= 0;
      y_m    <= 0;
      rem_m  <= 0;
    end else if (cnt_m > 0) begin
      cnt_m  <= cnt_m - 1;
      done_m <= cnt_m == 1;
      if (cnt_m == 1) begin
        y_m   <= fsqrt(x_m);
        rem_m <= x_m - fsqrt(x_m) * fsqrt(x_m);
      end
    end else begin
      done_m <= 0;
      if (start_i) begin
        x_m   <= int'(x_bi);
        cnt_m <= W / 2;
      end
    end
  end
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("busy", int'(busy_o), int'(cnt_m > 0));
      chk("done", int'(done_o), int'(done_m));
      chk("y", int'(y_bo), y_m);
`ifdef ISQRT_REM_EN
      chk("rem", int'(rem_bo), rem_m);
`endif
    end
  end
  task automatic start(input int x);
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi = W'(x);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!done_o && n < 20);
    if (!done_o) chk("done_timeout", 0, 1);
  endtask
  task automatic expect_res(input string nm, input int y, input int rem);
    chk({nm, "_y"}, int'(y_bo), y);
`ifdef ISQRT_REM_EN
    chk({nm, "_rem"}, int'(rem_bo), rem);
`else
    if (rem < 0) chk({nm, "_rem"}, rem, 0);
`endif
  endtask
  initial begin
    int n;
    chk("model_255", fsqrt(255), 15);
    chk("model_64", fsqrt(64), 8);
    chk("model_63", fsqrt(63), 7);
    chk("model_200", fsqrt(200), 14);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk_en = 1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_y", int'(y_bo), 0);
    start(0);
    wait_done(n);
    chk("lat_0", n, 4);
    expect_res("x0", 0, 0);
    start(255);
    wait_done(n);
    expect_res("x255", 15, 30);
    start(64);
    wait_done(n);
    expect_res("x64", 8, 0);
    start(63);
    wait_done(n);
    expect_res("x63", 7, 14);
    start(200);
    start_i = 1'b1;
    x_bi = 8'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(n);
    expect_res("busy_ignore", 14, 4);
    repeat (6) @(negedge clk_i);
    start(100);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_y", int'(y_bo), 0);
    repeat (6) @(negedge clk_i);
    start(100);
    wait_done(n);
    expect_res("x100", 10, 0);
    start(81);
    wait_done(n);
    expect_res("x81", 9, 0);
    start_i = 1'b1;
    x_bi = 8'd2;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("b2b_y_hold", int'(y_bo), 9);
    wait_done(n);
    chk("b2b_lat", n, 4);
    expect_res("x2", 1, 1);
    for (int x = 0; x < 256; x++) begin
      start(x);
      wait_done(n);
      chk("sweep_lat", n, 4);
    end
    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
